// File: rtl/multicycle_main_control.sv
// Main control FSM of the multi-cycle MIPS CPU: sequences IF/ID/EX/MEM/WB,
// drives datapath enables, mux selects and ALUOp; waits on mem_ready.
// Ports: clk, reset (async, active-low), OpCode/Funct (from IR),
//   mem_ready (memory handshake); outputs are datapath controls + illegal.
// Optional: define MAIN_CTRL_ILLEGAL_TRAP_EN to trap undecoded opcodes in S_HALT.
module multicycle_main_control #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OpCode,
    input  logic [5:0] Funct,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] MemtoReg,
    output logic [1:0] RegDst,
    output logic       RegWrite,
    output logic       ExtOp,
    output logic       LuiOp,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [3:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       illegal
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_JR   = 6'h08;
    localparam logic [5:0] F_JALR = 6'h09;

    typedef enum logic [3:0] {
        S_IF   = 4'd0,
        S_ID   = 4'd1,
        S_EXR  = 4'd2,
        S_WBR  = 4'd3,
        S_EXI  = 4'd4,
        S_WBI  = 4'd5,
        S_ADDR = 4'd6,
        S_MEMR = 4'd7,
        S_WBL  = 4'd8,
        S_MEMW = 4'd9,
        S_BR   = 4'd10,
        S_J    = 4'd11,
        S_JR   = 4'd12
`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
        , S_HALT = 4'd13
`endif
    } state_e;

    state_e state_q, state_d;

    // Raw strobes; gated by reset so nothing writes while reset is held.
    logic pcw_c, pcwc_c, mwr_c, irw_c, rw_c;

`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
    function automatic logic funct_ok(input logic [5:0] f);
        case (f)
            6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
            6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
            6'h26, 6'h27, 6'h2a, 6'h2b: funct_ok = 1'b1;
            default:                    funct_ok = 1'b0;
        endcase
    endfunction
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= state_e'(RESET_STATE);
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pcw_c    = 1'b0;
        pcwc_c   = 1'b0;
        mwr_c    = 1'b0;
        irw_c    = 1'b0;
        rw_c     = 1'b0;
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemtoReg = 2'b00;
        RegDst   = 2'b00;
        ExtOp    = 1'b1;
        LuiOp    = 1'b0;
        ALUSrcA  = 2'b00;
        ALUSrcB  = 2'b00;
        ALUOp    = 4'b0000;
        PCSource = 2'b00;
        case (state_q)
            S_IF: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                irw_c   = mem_ready;
                pcw_c   = mem_ready;
                if (mem_ready) state_d = S_ID;
            end
            S_ID: begin
                // Precompute branch target into ALUOut
                ALUSrcB = 2'b11;
                case (OpCode)
                    OP_RTYPE: begin
                        if (Funct == F_JR || Funct == F_JALR) begin
                            state_d = S_JR;
                        end else begin
`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
                            state_d = funct_ok(Funct) ? S_EXR : S_HALT;
`else
                            state_d = S_EXR;
`endif
                        end
                    end
                    OP_LW, OP_SW:   state_d = S_ADDR;
                    OP_BEQ:         state_d = S_BR;
                    OP_J, OP_JAL:   state_d = S_J;
                    OP_LUI, OP_ADDI, OP_ADDIU,
                    OP_ANDI, OP_SLTI, OP_SLTIU: state_d = S_EXI;
`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
                    default:        state_d = S_HALT;
`else
                    default:        state_d = S_IF;
`endif
                endcase
            end
            S_EXR: begin
                ALUSrcA = (Funct == F_SLL || Funct == F_SRL ||
                           Funct == F_SRA) ? 2'b10 : 2'b01;
                ALUOp   = 4'b0011;
                state_d = S_WBR;
            end
            S_WBR: begin
                RegDst  = 2'b01;
                rw_c    = 1'b1;
                state_d = S_IF;
            end
            S_EXI: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                ExtOp   = (OpCode != OP_ANDI);
                LuiOp   = (OpCode == OP_LUI);
                case (OpCode)
                    OP_ADDI, OP_LUI: ALUOp = 4'b0100;
                    OP_ANDI:         ALUOp = 4'b0110;
                    OP_SLTI:         ALUOp = 4'b0101;
                    OP_SLTIU:        ALUOp = 4'b0001;
                    default:         ALUOp = 4'b0000;
                endcase
                state_d = S_WBI;
            end
            S_WBI: begin
                // IR is stable, so extension controls stay as in S_EXI
                ExtOp   = (OpCode != OP_ANDI);
                LuiOp   = (OpCode == OP_LUI);
                rw_c    = 1'b1;
                state_d = S_IF;
            end
            S_ADDR: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                ALUOp   = 4'b0100;
                state_d = (OpCode == OP_SW) ? S_MEMW : S_MEMR;
            end
            S_MEMR: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) state_d = S_WBL;
            end
            S_WBL: begin
                MemtoReg = 2'b01;
                rw_c     = 1'b1;
                state_d  = S_IF;
            end
            S_MEMW: begin
                // Write commits only in the completing cycle
                mwr_c = mem_ready;
                IorD  = 1'b1;
                if (mem_ready) state_d = S_IF;
            end
            S_BR: begin
                ALUSrcA  = 2'b01;
                ALUOp    = 4'b0010;
                pcwc_c   = 1'b1;
                PCSource = 2'b01;
                state_d  = S_IF;
            end
            S_J: begin
                pcw_c    = 1'b1;
                PCSource = 2'b10;
                if (OpCode == OP_JAL) begin
                    rw_c     = 1'b1;
                    RegDst   = 2'b10;
                    MemtoReg = 2'b10;
                end
                state_d = S_IF;
            end
            S_JR: begin
                pcw_c    = 1'b1;
                PCSource = 2'b11;
                if (Funct == F_JALR) begin
                    rw_c     = 1'b1;
                    RegDst   = 2'b01;
                    MemtoReg = 2'b10;
                end
                state_d = S_IF;
            end
`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
            S_HALT: state_d = S_HALT;
`endif
            default: state_d = S_IF;
        endcase
    end

    assign PCWrite     = pcw_c & reset;
    assign PCWriteCond = pcwc_c & reset;
    assign MemWrite    = mwr_c & reset;
    assign IRWrite     = irw_c & reset;
    assign RegWrite    = rw_c & reset;

`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
    assign illegal = (state_q == S_HALT);
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_main_control.sv
// Self-checking bench for multicycle_main_control: per-cycle expected
// control vectors are queued per instruction and compared each cycle.
module tb_multicycle_main_control;

    typedef struct packed {
        logic       pcw, pcwc, iord, mrd, mwr, irw;
        logic [1:0] m2r, rdst;
        logic       rw, ext, lui;
        logic [1:0] sa, sb;
        logic [3:0] aop;
        logic [1:0] psrc;
        logic       ill;
    } ctl_t;

    typedef struct packed {
        logic mr;
        ctl_t c;
    } ent_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] OpCode, Funct;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic [1:0] MemtoReg, RegDst;
    logic       RegWrite, ExtOp, LuiOp;
    logic [1:0] ALUSrcA, ALUSrcB;
    logic [3:0] ALUOp;
    logic [1:0] PCSource;
    logic       illegal;

    ctl_t got;
    ent_t sbq[$];
    int   total = 0;
    int   bad = 0;

    multicycle_main_control dut (
        .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct),
        .mem_ready(mem_ready), .PCWrite(PCWrite),
        .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
        .RegDst(RegDst), .RegWrite(RegWrite), .ExtOp(ExtOp),
        .LuiOp(LuiOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .PCSource(PCSource), .illegal(illegal)
    );

    always #5 clk = ~clk;

    assign got = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                  MemtoReg, RegDst, RegWrite, ExtOp, LuiOp, ALUSrcA,
                  ALUSrcB, ALUOp, PCSource, illegal};

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    // Expected control vector per FSM phase
    function automatic ctl_t base();
        ctl_t c = '0;
        c.ext = 1'b1;
        return c;
    endfunction
    function automatic ctl_t e_rst();
        ctl_t c = base();
        c.mrd = 1'b1; c.sb = 2'b01;
        return c;
    endfunction
    function automatic ctl_t e_if(input logic mr);
        ctl_t c = e_rst();
        c.irw = mr; c.pcw = mr;
        return c;
    endfunction
    function automatic ctl_t e_id();
        ctl_t c = base();
        c.sb = 2'b11;
        return c;
    endfunction
    function automatic ctl_t e_exr(input logic sh);
        ctl_t c = base();
        c.sa = sh ? 2'b10 : 2'b01; c.aop = 4'b0011;
        return c;
    endfunction
    function automatic ctl_t e_wbr();
        ctl_t c = base();
        c.rdst = 2'b01; c.rw = 1'b1;
        return c;
    endfunction
    function automatic ctl_t e_exi(input logic [3:0] aop,
                                   input logic ext, input logic lui);
        ctl_t c = base();
        c.sa = 2'b01; c.sb = 2'b10; c.aop = aop; c.ext = ext; c.lui = lui;
        return c;
    endfunction
    function automatic ctl_t e_wbi(input logic ext, input logic lui);
        ctl_t c = base();
        c.rw = 1'b1; c.ext = ext; c.lui = lui;
        return c;
    endfunction
    function automatic ctl_t e_addr();
        ctl_t c = base();
        c.sa = 2'b01; c.sb = 2'b10; c.aop = 4'b0100;
        return c;
    endfunction
    function automatic ctl_t e_memr();
        ctl_t c = base();
        c.mrd = 1'b1; c.iord = 1'b1;
        return c;
    endfunction
    function automatic ctl_t e_wbl();
        ctl_t c = base();
        c.m2r = 2'b01; c.rw = 1'b1;
        return c;
    endfunction
    function automatic ctl_t e_memw(input logic mr);
        ctl_t c = base();
        c.mwr = mr; c.iord = 1'b1;
        return c;
    endfunction
    function automatic ctl_t e_br();
        ctl_t c = base();
        c.sa = 2'b01; c.aop = 4'b0010; c.pcwc = 1'b1; c.psrc = 2'b01;
        return c;
    endfunction
    function automatic ctl_t e_j(input logic link);
        ctl_t c = base();
        c.pcw = 1'b1; c.psrc = 2'b10;
        if (link) begin c.rw = 1'b1; c.rdst = 2'b10; c.m2r = 2'b10; end
        return c;
    endfunction
    function automatic ctl_t e_jr(input logic link);
        ctl_t c = base();
        c.pcw = 1'b1; c.psrc = 2'b11;
        if (link) begin c.rw = 1'b1; c.rdst = 2'b01; c.m2r = 2'b10; end
        return c;
    endfunction
    function automatic ctl_t e_halt();
        ctl_t c = base();
        c.ill = 1'b1;
        return c;
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input logic mr, input ctl_t c);
        sbq.push_back({mr, c});
    endtask

    // Queue the expected per-cycle outputs of one instruction
    task automatic push_instr(input logic [5:0] op, input logic [5:0] fn,
                              input int ifw, input int memw);
        for (int i = 0; i < ifw; i++) push(1'b0, e_if(1'b0));
        push(1'b1, e_if(1'b1));
        push(rnd(), e_id());
        case (op)
            6'h00: begin
                if (fn == 6'h08 || fn == 6'h09) begin
                    push(rnd(), e_jr(fn == 6'h09));
                end else begin
                    push(rnd(), e_exr(fn == 6'h00 || fn == 6'h02 ||
                                      fn == 6'h03));
                    push(rnd(), e_wbr());
                end
            end
            6'h23: begin
                push(rnd(), e_addr());
                for (int i = 0; i < memw; i++) push(1'b0, e_memr());
                push(1'b1, e_memr());
                push(rnd(), e_wbl());
            end
            6'h2b: begin
                push(rnd(), e_addr());
                for (int i = 0; i < memw; i++) push(1'b0, e_memw(1'b0));
                push(1'b1, e_memw(1'b1));
            end
            6'h04: push(rnd(), e_br());
            6'h02: push(rnd(), e_j(1'b0));
            6'h03: push(rnd(), e_j(1'b1));
            6'h08: begin
                push(rnd(), e_exi(4'b0100, 1'b1, 1'b0));
                push(rnd(), e_wbi(1'b1, 1'b0));
            end
            6'h09: begin
                push(rnd(), e_exi(4'b0000, 1'b1, 1'b0));
                push(rnd(), e_wbi(1'b1, 1'b0));
            end
            6'h0c: begin
                push(rnd(), e_exi(4'b0110, 1'b0, 1'b0));
                push(rnd(), e_wbi(1'b0, 1'b0));
            end
            6'h0a: begin
                push(rnd(), e_exi(4'b0101, 1'b1, 1'b0));
                push(rnd(), e_wbi(1'b1, 1'b0));
            end
            6'h0b: begin
                push(rnd(), e_exi(4'b0001, 1'b1, 1'b0));
                push(rnd(), e_wbi(1'b1, 1'b0));
            end
            6'h0f: begin
                push(rnd(), e_exi(4'b0100, 1'b1, 1'b1));
                push(rnd(), e_wbi(1'b1, 1'b1));
            end
            default: ;
        endcase
    endtask

    // Pop one entry per cycle: drive mem_ready, compare at negedge
    task automatic run_queue(input string name);
        int   n = 0;
        ent_t e;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            mem_ready = e.mr;
            @(negedge clk);
            total++;
            if (got !== e.c) begin
                bad++;
                $display("FAIL %s cyc%0d got=%h want=%h", name, n, got, e.c);
            end
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_now(input string name, input ctl_t want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic do_instr(input string name, input logic [5:0] op,
                            input logic [5:0] fn, input int ifw,
                            input int memw);
        OpCode = op;
        Funct  = fn;
        push_instr(op, fn, ifw, memw);
        run_queue(name);
    endtask

    // Reset pulse from posedge+1; leaves the FSM idle in S_IF at posedge+1
    task automatic pulse_reset(input string name);
        reset = 1'b0;
        #1;
        check_now(name, e_rst());
        mem_ready = 1'b0;
        @(negedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        mem_ready = 1'b0;
        OpCode = 6'h00;
        Funct = 6'h00;
        #2;
        check_now("reset_mr0", e_rst());
        mem_ready = 1'b1;
        #1;
        check_now("reset_mr1", e_rst());
        @(posedge clk);
        #1;
        check_now("reset_hold", e_rst());
        reset = 1'b1;
    endtask

    task automatic test_rtype();
        do_instr("addu", 6'h00, 6'h21, 0, 0);
        do_instr("sll", 6'h00, 6'h00, 0, 0);
        do_instr("sra_wait", 6'h00, 6'h03, 2, 0);
    endtask

    task automatic test_load_store();
        do_instr("lw_w2", 6'h23, 6'h00, 0, 2);
        do_instr("lw_w0", 6'h23, 6'h00, 0, 0);
        do_instr("sw_w0", 6'h2b, 6'h00, 0, 0);
        do_instr("sw_w3", 6'h2b, 6'h00, 1, 3);
    endtask

    task automatic test_itype();
        do_instr("addi", 6'h08, 6'h15, 0, 0);
        do_instr("addiu", 6'h09, 6'h00, 0, 0);
        do_instr("andi", 6'h0c, 6'h00, 0, 0);
        do_instr("slti", 6'h0a, 6'h00, 0, 0);
        do_instr("sltiu", 6'h0b, 6'h00, 0, 0);
        do_instr("lui", 6'h0f, 6'h00, 0, 0);
    endtask

    task automatic test_branch_jump();
        do_instr("beq", 6'h04, 6'h00, 0, 0);
        do_instr("j", 6'h02, 6'h00, 0, 0);
        do_instr("jal", 6'h03, 6'h00, 0, 0);
        do_instr("jr", 6'h00, 6'h08, 0, 0);
        do_instr("jalr", 6'h00, 6'h09, 1, 0);
    endtask

    task automatic test_reset_abort();
        OpCode = 6'h2b;
        Funct  = 6'h00;
        push(1'b1, e_if(1'b1));
        push(1'b1, e_id());
        push(1'b1, e_addr());
        run_queue("abort_pre");
        mem_ready = 1'b1;
        #2;
        check_now("abort_memw", e_memw(1'b1));
        reset = 1'b0;
        #1;
        check_now("abort_in_reset", e_rst());
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_now("abort_release", e_if(1'b1));
        @(posedge clk);
        #1;
        push(1'b1, e_id());
        push(1'b1, e_addr());
        push(1'b1, e_memw(1'b1));
        run_queue("abort_post");
    endtask

    task automatic test_illegal();
`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
        OpCode = 6'h3f;
        Funct  = 6'h00;
        push(1'b1, e_if(1'b1));
        push(1'b1, e_id());
        for (int i = 0; i < 12; i++) push(rnd(), e_halt());
        run_queue("illegal_op");
        pulse_reset("illegal_op_rst");
        OpCode = 6'h00;
        Funct  = 6'h3f;
        push(1'b1, e_if(1'b1));
        push(1'b1, e_id());
        for (int i = 0; i < 11; i++) push(rnd(), e_halt());
        run_queue("illegal_fn");
        pulse_reset("illegal_fn_rst");
`else
        OpCode = 6'h3f;
        Funct  = 6'h00;
        push(1'b1, e_if(1'b1));
        push(1'b1, e_id());
        push(1'b0, e_if(1'b0));
        push(1'b1, e_if(1'b1));
        push(1'b1, e_id());
        run_queue("nop_op");
        do_instr("addu_after", 6'h00, 6'h21, 0, 0);
        do_instr("undef_fn", 6'h00, 6'h3f, 0, 0);
`endif
    endtask

    task automatic test_back_to_back();
        logic [5:0] opt [14];
        logic [5:0] fnt [14];
        int k;
        opt = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h23, 6'h2b, 6'h04,
                6'h02, 6'h03, 6'h08, 6'h09, 6'h0c, 6'h0a, 6'h0f};
        fnt = '{6'h21, 6'h02, 6'h08, 6'h09, 6'h00, 6'h00, 6'h00,
                6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
        for (int i = 0; i < 30; i++) begin
            k = int'($urandom_range(0, 13));
            do_instr("b2b", opt[k], fnt[k],
                     int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_load_store();
        test_itype();
        test_branch_jump();
        test_reset_abort();
        test_illegal();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
